// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing aligned 64-bit load/store requests and registering writeback fields.
// Optional response watchdog enabled by defining MAU_RSP_TIMEOUT_EN.
module mem_access_unit #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic            ex_load_i,
  input  logic            ex_store_i,
  input  logic [XLEN-1:0] ex_alu_res_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic [1:0]      ex_byte_en_i,
  input  logic            ex_zero_extnd_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [1:0]      ex_rf_wr_data_src_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wstrb_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_alu_res_o,
  output logic [XLEN-1:0] wb_data_mem_rd_o,
  output logic [XLEN-1:0] wb_imm_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [1:0]      wb_rf_wr_data_src_o,
  output logic [1:0]      wb_byte_en_o,
  output logic            wb_zero_extnd_o,
  output logic [2:0]      wb_row_idx_o,
  output logic            wb_misalign_o,
  output logic            wb_bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_alu, r_imm, r_pc;
  logic [1:0] r_src, r_be;
  logic r_zext;
  logic w_accept, w_mem, w_mis, w_fast, w_issue, w_st_done, w_ld_done, w_tmo, w_done;
  logic [2:0] w_off;
  logic [7:0] w_strb;
  assign w_off     = ex_alu_res_i[2:0];
  assign w_accept  = ex_valid_i && r_state == IDLE;
  assign w_mem     = ex_load_i || ex_store_i;
  assign w_mis     = w_mem && ((ex_byte_en_i == 2'd1 && w_off[0]) ||
                               (ex_byte_en_i == 2'd2 && |w_off[1:0]) ||
                               (ex_byte_en_i == 2'd3 && |w_off));
  assign w_fast    = w_accept && (!w_mem || w_mis);
  assign w_issue   = w_accept && w_mem && !w_mis;
  assign w_st_done = r_state == REQ && dmem_gnt_i && dmem_we_o;
  assign w_ld_done = r_state == RSP && dmem_rvalid_i;
  assign w_done    = w_st_done || w_ld_done || w_tmo;
  assign w_strb    = ex_byte_en_i == 2'd0 ? 8'h01 : ex_byte_en_i == 2'd1 ? 8'h03 :
                     ex_byte_en_i == 2'd2 ? 8'h0F : 8'hFF;
  assign ex_ready_o = r_state == IDLE;
  assign dmem_req_o = r_state == REQ;
`ifdef MAU_RSP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // A grant or response in the final watchdog cycle still wins over the timeout.
  assign w_tmo = r_state != IDLE && r_cnt == CW'(TIMEOUT_CYCLES - 1) &&
                 !(r_state == REQ && dmem_gnt_i) && !w_ld_done;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_cnt <= '0;
    else r_cnt <= (r_state == IDLE || w_next != r_state) ? '0 : r_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_issue ? REQ : IDLE;
      REQ:     w_next = dmem_gnt_i ? (dmem_we_o ? IDLE : RSP) : (w_tmo ? IDLE : REQ);
      RSP:     w_next = (dmem_rvalid_i || w_tmo) ? IDLE : RSP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      {r_alu, r_imm, r_pc, r_src, r_be, r_zext} <= '0;
      {dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o} <= '0;
      {wb_valid_o, wb_alu_res_o, wb_data_mem_rd_o, wb_imm_o, wb_pc_o} <= '0;
      {wb_rf_wr_data_src_o, wb_byte_en_o, wb_zero_extnd_o, wb_row_idx_o} <= '0;
      {wb_misalign_o, wb_bus_err_o} <= '0;
    end else begin
      wb_valid_o <= w_fast || w_done;
      if (w_accept) begin
        r_alu  <= ex_alu_res_i;
        r_imm  <= ex_imm_i;
        r_pc   <= ex_pc_i;
        r_src  <= ex_rf_wr_data_src_i;
        r_be   <= ex_byte_en_i;
        r_zext <= ex_zero_extnd_i;
      end
      if (w_issue) begin
        dmem_addr_o  <= {ex_alu_res_i[XLEN-1:3], 3'b000};
        dmem_we_o    <= ex_store_i;
        dmem_wdata_o <= ex_store_i ? ex_store_data_i << {w_off, 3'b000} : '0;
        dmem_wstrb_o <= ex_store_i ? w_strb << w_off : 8'h00;
      end
      // Single-cycle completions take fields straight from execute; memory ones from the holding registers.
      if (w_fast) begin
        wb_alu_res_o        <= ex_alu_res_i;
        wb_imm_o            <= ex_imm_i;
        wb_pc_o             <= ex_pc_i;
        wb_rf_wr_data_src_o <= ex_rf_wr_data_src_i;
        wb_byte_en_o        <= ex_byte_en_i;
        wb_zero_extnd_o     <= ex_zero_extnd_i;
        wb_row_idx_o        <= w_off;
        wb_misalign_o       <= w_mis;
        wb_bus_err_o        <= 1'b0;
      end else if (w_done) begin
        wb_alu_res_o        <= r_alu;
        wb_imm_o            <= r_imm;
        wb_pc_o             <= r_pc;
        wb_rf_wr_data_src_o <= r_src;
        wb_byte_en_o        <= r_be;
        wb_zero_extnd_o     <= r_zext;
        wb_row_idx_o        <= r_alu[2:0];
        wb_misalign_o       <= 1'b0;
        wb_bus_err_o        <= w_tmo;
      end
      if (w_ld_done) wb_data_mem_rd_o <= dmem_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory stage with immediate assertions.
module tb_mem_access_unit;
  logic clk_i = 1'b0, resetn_i = 1'b0;
  logic ex_valid_i = 0, ex_ready_o, ex_load_i = 0, ex_store_i = 0, ex_zero_extnd_i = 0;
  logic [63:0] ex_alu_res_i = 0, ex_store_data_i = 0, ex_imm_i = 0, ex_pc_i = 0;
  logic [1:0] ex_byte_en_i = 0, ex_rf_wr_data_src_i = 0;
  logic dmem_req_o, dmem_we_o, dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = 0;
  logic [7:0] dmem_wstrb_o;
  logic wb_valid_o, wb_zero_extnd_o, wb_misalign_o, wb_bus_err_o;
  logic [63:0] wb_alu_res_o, wb_data_mem_rd_o, wb_imm_o, wb_pc_o;
  logic [1:0] wb_rf_wr_data_src_o, wb_byte_en_o;
  logic [2:0] wb_row_idx_o;
  int n_cmp = 0, n_err = 0;

  mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_load_i(ex_load_i), .ex_store_i(ex_store_i), .ex_alu_res_i(ex_alu_res_i),
    .ex_store_data_i(ex_store_data_i), .ex_byte_en_i(ex_byte_en_i),
    .ex_zero_extnd_i(ex_zero_extnd_i), .ex_imm_i(ex_imm_i), .ex_pc_i(ex_pc_i),
    .ex_rf_wr_data_src_i(ex_rf_wr_data_src_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_alu_res_o(wb_alu_res_o), .wb_data_mem_rd_o(wb_data_mem_rd_o),
    .wb_imm_o(wb_imm_o), .wb_pc_o(wb_pc_o), .wb_rf_wr_data_src_o(wb_rf_wr_data_src_o),
    .wb_byte_en_o(wb_byte_en_o), .wb_zero_extnd_o(wb_zero_extnd_o), .wb_row_idx_o(wb_row_idx_o),
    .wb_misalign_o(wb_misalign_o), .wb_bus_err_o(wb_bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] be);
    ex_valid_i = 1; ex_load_i = ld; ex_store_i = st;
    ex_alu_res_i = a; ex_store_data_i = d; ex_byte_en_i = be;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_alu", wb_alu_res_o, 0);
    chk("rst_wstrb", dmem_wstrb_o, 0);
    chk("rst_bus_err", wb_bus_err_o, 0);
    resetn_i = 1;
    tick();
    // non-memory ops back to back
    drive(0, 0, 64'h1234, 0, 2'd3);
    ex_imm_i = 64'h55; ex_pc_i = 64'h400; ex_rf_wr_data_src_i = 2'd0;
    chk("nm_ready", ex_ready_o, 1);
    tick();
    ex_alu_res_i = 64'h777;
    chk("nm_valid", wb_valid_o, 1);
    chk("nm_alu", wb_alu_res_o, 64'h1234);
    chk("nm_imm", wb_imm_o, 64'h55);
    chk("nm_pc", wb_pc_o, 64'h400);
    chk("nm_req", dmem_req_o, 0);
    chk("nm_mis", wb_misalign_o, 0);
    tick();
    ex_valid_i = 0;
    chk("nm2_valid", wb_valid_o, 1);
    chk("nm2_alu", wb_alu_res_o, 64'h777);
    tick();
    chk("nm_idle_valid", wb_valid_o, 0);
    chk("nm_hold_alu", wb_alu_res_o, 64'h777);
    // byte store at 0x1005, gnt in the third request cycle
    drive(0, 1, 64'h1005, 64'hAB, 2'd0);
    tick();
    ex_valid_i = 0;
    chk("st_req1", dmem_req_o, 1);
    chk("st_addr", dmem_addr_o, 64'h1000);
    chk("st_wstrb", dmem_wstrb_o, 8'h20);
    chk("st_wdata", dmem_wdata_o, 64'h0000_AB00_0000_0000);
    chk("st_we", dmem_we_o, 1);
    chk("st_ready", ex_ready_o, 0);
    tick();
    chk("st_req2", dmem_req_o, 1);
    chk("st_addr2", dmem_addr_o, 64'h1000);
    chk("st_no_wb", wb_valid_o, 0);
    tick();
    chk("st_req3", dmem_req_o, 1);
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    chk("st_req_drop", dmem_req_o, 0);
    chk("st_valid", wb_valid_o, 1);
    chk("st_row", wb_row_idx_o, 5);
    chk("st_alu", wb_alu_res_o, 64'h1005);
    chk("st_ready_back", ex_ready_o, 1);
    tick();
    chk("st_valid_pulse", wb_valid_o, 0);
    // word load at 0x2004, gnt at once, rvalid two cycles later
    drive(1, 0, 64'h2004, 0, 2'd2);
    tick();
    ex_valid_i = 0;
    chk("ld_req", dmem_req_o, 1);
    chk("ld_addr", dmem_addr_o, 64'h2000);
    chk("ld_wstrb", dmem_wstrb_o, 0);
    chk("ld_we", dmem_we_o, 0);
    chk("ld_ready1", ex_ready_o, 0);
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    chk("ld_req_rsp", dmem_req_o, 0);
    chk("ld_ready2", ex_ready_o, 0);
    tick();
    chk("ld_ready3", ex_ready_o, 0);
    chk("ld_no_wb", wb_valid_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 64'h89AB_CDEF_0123_4567;
    tick();
    dmem_rvalid_i = 0;
    chk("ld_valid", wb_valid_o, 1);
    chk("ld_rdata", wb_data_mem_rd_o, 64'h89AB_CDEF_0123_4567);
    chk("ld_row", wb_row_idx_o, 4);
    chk("ld_be", wb_byte_en_o, 2);
    // stray rvalid while idle is ignored
    dmem_rvalid_i = 1; dmem_rdata_i = 64'hDEAD_BEEF;
    tick();
    dmem_rvalid_i = 0;
    tick();
    chk("stray_valid", wb_valid_o, 0);
    chk("stray_rdata", wb_data_mem_rd_o, 64'h89AB_CDEF_0123_4567);
    // misaligned half load
    drive(1, 0, 64'h3003, 0, 2'd1);
    tick();
    ex_valid_i = 0;
    chk("mis_req", dmem_req_o, 0);
    chk("mis_valid", wb_valid_o, 1);
    chk("mis_flag", wb_misalign_o, 1);
    chk("mis_row", wb_row_idx_o, 3);
    chk("mis_ready", ex_ready_o, 1);
    tick();
    chk("mis_pulse", wb_valid_o, 0);
    chk("mis_req2", dmem_req_o, 0);
    // reset while waiting for load data
    drive(1, 0, 64'h4000, 0, 2'd3);
    ex_zero_extnd_i = 1;
    tick();
    ex_valid_i = 0;
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    chk("rr_rsp_ready", ex_ready_o, 0);
    resetn_i = 0;
    #1;
    chk("rr_req", dmem_req_o, 0);
    chk("rr_ready", ex_ready_o, 1);
    chk("rr_alu", wb_alu_res_o, 0);
    chk("rr_rdata", wb_data_mem_rd_o, 0);
    chk("rr_addr", dmem_addr_o, 0);
    chk("rr_mis", wb_misalign_o, 0);
    tick();
    resetn_i = 1;
    dmem_rvalid_i = 1; dmem_rdata_i = 64'h1111_2222_3333_4444;
    tick();
    dmem_rvalid_i = 0;
    chk("rr_late_valid", wb_valid_o, 0);
    chk("rr_late_rdata", wb_data_mem_rd_o, 0);
    chk("rr_idle", ex_ready_o, 1);
    // store that is never granted
    drive(0, 1, 64'h5000, 64'h1, 2'd3);
    tick();
    ex_valid_i = 0;
    chk("to_wstrb", dmem_wstrb_o, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", dmem_req_o, 1);
      if (i < 3) tick();
    end
    tick();
`ifdef MAU_RSP_TIMEOUT_EN
    chk("to_req_drop", dmem_req_o, 0);
    chk("to_valid", wb_valid_o, 1);
    chk("to_bus_err", wb_bus_err_o, 1);
    chk("to_ready", ex_ready_o, 1);
`else
    chk("nto_req_held", dmem_req_o, 1);
    chk("nto_no_wb", wb_valid_o, 0);
    tick();
    chk("nto_req_held2", dmem_req_o, 1);
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    chk("nto_valid", wb_valid_o, 1);
    chk("nto_bus_err", wb_bus_err_o, 0);
    chk("nto_row", wb_row_idx_o, 0);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access pipeline stage between execute and writeback.
- Accepts one instruction at a time from execute. Issues aligned 64-bit load/store requests to the data memory over a req/gnt/rvalid handshake and builds store data and byte strobes.
- Registers the row data and decode fields that writeback needs: result, raw memory row, byte size, extension flag, row index.
- Stalls execute while a memory transaction is outstanding.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TIMEOUT_CYCLES, 256, response watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous active-low reset
- ex_valid_i  in  1  execute presents an instruction
- ex_ready_o  out  1  stage can accept
- ex_load_i  in  1  instruction is a load
- ex_store_i  in  1  instruction is a store
- ex_alu_res_i  in  64  ALU result; effective address for loads/stores
- ex_store_data_i  in  64  rs2 value, unshifted
- ex_byte_en_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- ex_zero_extnd_i  in  1  extension control, passed through unchanged
- ex_imm_i  in  64  immediate, passed through
- ex_pc_i  in  64  PC value, passed through
- ex_rf_wr_data_src_i  in  2  writeback source select, passed through
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  row-aligned address
- dmem_wdata_o  out  64  lane-shifted store data
- dmem_wstrb_o  out  8  byte write strobes
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  64  load row data
- wb_valid_o  out  1  one-cycle pulse; instruction complete
- wb_alu_res_o  out  64  registered result
- wb_data_mem_rd_o  out  64  registered raw memory row
- wb_imm_o, wb_pc_o  out  64 each  registered pass-through
- wb_rf_wr_data_src_o  out  2  registered pass-through
- wb_byte_en_o  out  2  registered pass-through
- wb_zero_extnd_o  out  1  registered pass-through
- wb_row_idx_o  out  3  registered address bits [2:0]
- wb_misalign_o  out  1  misaligned-access flag
- wb_bus_err_o  out  1  timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (asynchronous, active-low):
  - Every registered output goes to 0 and the state machine goes to IDLE.
  - Asserting reset mid-transaction drops dmem_req_o immediately.
  - A late dmem_rvalid_i after reset is ignored.
- States:
  - IDLE: ex_ready_o = 1, combinational.
  - REQ: dmem_req_o = 1.
  - RSP: load waiting for data.
  - ex_ready_o = 0 in REQ and RSP.
- Accept: ex_valid_i && ex_ready_o in IDLE. All ex_* inputs are captured into internal holding registers.
- Non-memory op (load = store = 0): wb_valid_o pulses on the next cycle with the captured fields. Latency 1; stays in IDLE, so back-to-back accepts are allowed.
- Misalignment check:
  - Misaligned if half has addr[0] ≠ 0, word has addr[1:0] ≠ 0, or double has addr[2:0] ≠ 0.
  - No memory request is issued.
  - Next cycle: wb_valid_o = 1 and wb_misalign_o = 1; stays in IDLE.
- Aligned load/store: move to REQ on the next cycle. dmem_addr_o, dmem_we_o, dmem_wdata_o and dmem_wstrb_o are registered and held stable until dmem_gnt_i.
  - dmem_addr_o = {addr[63:3], 000}.
  - dmem_wdata_o = store_data << (addr[2:0]*8).
  - dmem_wstrb_o = 0x01 / 0x03 / 0x0F / 0xFF << addr[2:0], for byte / half / word / double.
  - For loads, dmem_wstrb_o = 0 and dmem_we_o = 0.
- REQ + gnt:
  - Store: dmem_req_o drops; the cycle after gnt, wb_valid_o pulses and the state returns to IDLE.
  - Load: go to RSP.
- RSP + rvalid:
  - dmem_rdata_i is captured into wb_data_mem_rd_o and wb_valid_o pulses the next cycle; return to IDLE.
  - dmem_rvalid_i is ignored outside RSP. The memory never returns rvalid in the gnt cycle.
- wb_row_idx_o = addr[2:0] of the completed instruction.
- The wb_* data outputs hold their last value when wb_valid_o = 0.
- Minimum latencies: load 3 cycles, store 2 cycles, from accept to wb_valid_o.

Optional Feature:
- Macro MAU_RSP_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to REQ or RSP and increments each cycle spent in REQ or RSP.
  - When it reaches TIMEOUT_CYCLES: dmem_req_o drops, the next cycle pulses wb_valid_o with wb_bus_err_o = 1, and the state returns to IDLE.
- When undefined: no counter exists, wb_bus_err_o = 0, and the stage waits indefinitely.

Test Plan:
- Non-memory op, alu_res = 0x1234, src = ALU → wb_valid_o the next cycle, wb_alu_res_o = 0x1234, no dmem_req_o.
- Byte store at address 0x1005, data 0xAB, gnt after 2 cycles → dmem_addr_o = 0x1000, dmem_wstrb_o = 0x20, dmem_wdata_o = 0xAB << 40, req held for 3 cycles, wb_valid_o one cycle after gnt.
- Word load at 0x2004, gnt immediately, rvalid 2 cycles later with rdata 0x89ABCDEF01234567 → wb_data_mem_rd_o = 0x89ABCDEF01234567, wb_row_idx_o = 4, ex_ready_o = 0 throughout.
- Half load at 0x3003 → no dmem_req_o, wb_valid_o with wb_misalign_o = 1 the next cycle.
- resetn_i asserted in RSP, then rvalid arrives → all outputs 0, IDLE, no wb_valid_o.
- With MAU_RSP_TIMEOUT_EN and TIMEOUT_CYCLES = 4, gnt never asserted → req drops after 4 cycles, wb_bus_err_o = 1.
